midi_msg_parser: RTL and testbench

//   Turns the serial MIDI byte stream from the UART receiver into complete

---
 rtl/midi_msg_parser.sv | 144 ++++++++++++++
 tb/tb_midi_msg_parser.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/midi_msg_parser.sv
// ============================================================================
//  Module   : midi_msg_parser
//  Purpose  : Assembles UART MIDI bytes into complete channel/system messages.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module midi_msg_parser #(
  parameter bit VEL0_IS_NOTE_OFF = 1'b1,
  parameter bit EMIT_REALTIME    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx_rdy,
  input  logic [7:0] uart_rx_data,
  output logic       midi_rdy,
  output logic [3:0] midi_cmd,
  output logic [3:0] midi_ch_sysn,
  output logic [6:0] midi_data0,
  output logic [6:0] midi_data1
);

  localparam int         MIDI_CMD_SIZE        = 4;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NONE        = 4'd0;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_OFF    = 4'd1;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_ON     = 4'd2;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_AFTERTOUCH  = 4'd3;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_CC          = 4'd4;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_PROG_CHANGE = 4'd5;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_CH_PRESSURE = 4'd6;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_PITCH_BEND  = 4'd7;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_SYSTEM      = 4'd8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D0 = 2'd1,
    WAIT_D1 = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t     state_q;
  logic [3:0] rs_cmd_q;
  logic [3:0] rs_ch_q;
  logic       rs_2b_q;
  logic [6:0] d0_q;

  logic [3:0] status_cmd;
  logic       status_2b;
  logic       is_realtime;
  logic       is_syscommon;
  logic [3:0] d1_cmd;

  always_comb begin
    status_cmd = MIDI_CMD_NONE;
    status_2b  = 1'b0;
    case (uart_rx_data[7:4])
      4'h8:    begin status_cmd = MIDI_CMD_NOTE_OFF;    status_2b = 1'b1; end
      4'h9:    begin status_cmd = MIDI_CMD_NOTE_ON;     status_2b = 1'b1; end
      4'hA:    begin status_cmd = MIDI_CMD_AFTERTOUCH;  status_2b = 1'b1; end
      4'hB:    begin status_cmd = MIDI_CMD_CC;          status_2b = 1'b1; end
      4'hC:    begin status_cmd = MIDI_CMD_PROG_CHANGE; status_2b = 1'b0; end
      4'hD:    begin status_cmd = MIDI_CMD_CH_PRESSURE; status_2b = 1'b0; end
      4'hE:    begin status_cmd = MIDI_CMD_PITCH_BEND;  status_2b = 1'b1; end
      default: begin status_cmd = MIDI_CMD_NONE;        status_2b = 1'b0; end
    endcase
  end

  assign is_realtime  = (uart_rx_data[7:3] == 5'b11111);
  assign is_syscommon = (uart_rx_data[7:3] == 5'b11110);

  // A NOTE_ON completing with zero velocity is reported as a NOTE_OFF.
  assign d1_cmd = (VEL0_IS_NOTE_OFF && rs_cmd_q == MIDI_CMD_NOTE_ON &&
                   uart_rx_data[6:0] == 7'd0) ? MIDI_CMD_NOTE_OFF : rs_cmd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rs_cmd_q     <= MIDI_CMD_NONE;
      rs_ch_q      <= 4'd0;
      rs_2b_q      <= 1'b0;
      d0_q         <= 7'd0;
      midi_rdy     <= 1'b0;
      midi_cmd     <= MIDI_CMD_NONE;
      midi_ch_sysn <= 4'd0;
      midi_data0   <= 7'd0;
      midi_data1   <= 7'd0;
    end else begin
      midi_rdy <= 1'b0;
      if (uart_rx_rdy) begin
        if (uart_rx_data[7]) begin
          if (is_realtime) begin
            // Real-time bytes never disturb the message being assembled.
            if (EMIT_REALTIME) begin
              midi_rdy     <= 1'b1;
              midi_cmd     <= MIDI_CMD_SYSTEM;
              midi_ch_sysn <= uart_rx_data[3:0];
              midi_data0   <= 7'd0;
              midi_data1   <= 7'd0;
            end
          end else if (is_syscommon) begin
            state_q  <= DISCARD;
            rs_cmd_q <= MIDI_CMD_NONE;
            rs_ch_q  <= 4'd0;
            rs_2b_q  <= 1'b0;
          end else begin
            state_q  <= WAIT_D0;
            rs_cmd_q <= status_cmd;
            rs_ch_q  <= uart_rx_data[3:0];
            rs_2b_q  <= status_2b;
          end
        end else begin
          case (state_q)
            WAIT_D0: begin
              d0_q <= uart_rx_data[6:0];
              if (rs_2b_q) begin
                state_q <= WAIT_D1;
              end else begin
                midi_rdy     <= 1'b1;
                midi_cmd     <= rs_cmd_q;
                midi_ch_sysn <= rs_ch_q;
                midi_data0   <= uart_rx_data[6:0];
                midi_data1   <= 7'd0;
              end
            end
            WAIT_D1: begin
              state_q      <= WAIT_D0;
              midi_rdy     <= 1'b1;
              midi_cmd     <= d1_cmd;
              midi_ch_sysn <= rs_ch_q;
              midi_data0   <= d0_q;
              midi_data1   <= uart_rx_data[6:0];
            end
            default: begin
              state_q <= state_q;
            end
          endcase
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_midi_msg_parser.sv
// Directed bench for midi_msg_parser: two instances (real-time emit on/off)
// share one byte stream; emitted messages are collected and compared.
`default_nettype none

module tb_midi_msg_parser;

  localparam logic [3:0] C_NONE  = 4'd0;
  localparam logic [3:0] C_NOFF  = 4'd1;
  localparam logic [3:0] C_NON   = 4'd2;
  localparam logic [3:0] C_CC    = 4'd4;
  localparam logic [3:0] C_PROG  = 4'd5;
  localparam logic [3:0] C_PB    = 4'd7;
  localparam logic [3:0] C_SYS   = 4'd8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;

  logic       a_rdy, b_rdy;
  logic [3:0] a_cmd, b_cmd, a_ch, b_ch;
  logic [6:0] a_d0, b_d0, a_d1, b_d1;

  int n_checks = 0;
  int n_errors = 0;

  logic [21:0] q_a[$];
  logic [21:0] q_b[$];

  always #5 clk = ~clk;

  midi_msg_parser #(.VEL0_IS_NOTE_OFF(1'b1), .EMIT_REALTIME(1'b1)) dut (
    .clk(clk), .reset(rst_n), .uart_rx_rdy(rx_rdy), .uart_rx_data(rx_data),
    .midi_rdy(a_rdy), .midi_cmd(a_cmd), .midi_ch_sysn(a_ch),
    .midi_data0(a_d0), .midi_data1(a_d1)
  );

  midi_msg_parser #(.VEL0_IS_NOTE_OFF(1'b1), .EMIT_REALTIME(1'b0)) dut_nrt (
    .clk(clk), .reset(rst_n), .uart_rx_rdy(rx_rdy), .uart_rx_data(rx_data),
    .midi_rdy(b_rdy), .midi_cmd(b_cmd), .midi_ch_sysn(b_ch),
    .midi_data0(b_d0), .midi_data1(b_d1)
  );

  always @(negedge clk) begin
    if (a_rdy) q_a.push_back({a_cmd, a_ch, a_d0, a_d1});
    if (b_rdy) q_b.push_back({b_cmd, b_ch, b_d0, b_d1});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Single strobe with an idle cycle after it.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_rdy  = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_rdy  = 1'b0;
  endtask

  // Strobes on consecutive cycles.
  task automatic burst(input logic [7:0] bytes[$]);
    foreach (bytes[i]) begin
      @(negedge clk);
      rx_rdy  = 1'b1;
      rx_data = bytes[i];
    end
    @(negedge clk);
    rx_rdy = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic pop_a(input string tag, input logic [3:0] cmd, input logic [3:0] ch,
                       input logic [6:0] d0, input logic [6:0] d1);
    logic [21:0] m;
    if (q_a.size() == 0) begin
      check({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      m = q_a.pop_front();
      check({tag, "_cmd"}, 32'(m[21:18]), 32'(cmd));
      check({tag, "_ch"},  32'(m[17:14]), 32'(ch));
      check({tag, "_d0"},  32'(m[13:7]),  32'(d0));
      check({tag, "_d1"},  32'(m[6:0]),   32'(d1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"}, 32'(a_rdy), 32'd0);
    check({tag, "_cmd"}, 32'(a_cmd), 32'(C_NONE));
    check({tag, "_ch"},  32'(a_ch),  32'd0);
    check({tag, "_d0"},  32'(a_d0),  32'd0);
    check({tag, "_d1"},  32'(a_d1),  32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    settle();

    // Note-on with latency check on the completing byte.
    send(8'h90);
    send(8'h32);
    check("t1_no_early_rdy", 32'(a_rdy), 32'd0);
    @(negedge clk);
    rx_rdy  = 1'b1;
    rx_data = 8'h30;
    check("t1_rdy_not_yet", 32'(a_rdy), 32'd0);
    @(negedge clk);
    rx_rdy = 1'b0;
    check("t1_rdy_latency", 32'(a_rdy), 32'd1);
    settle();
    check("t1_count", 32'(q_a.size()), 32'd1);
    pop_a("t1", C_NON, 4'd0, 7'd50, 7'd48);

    // Running status, back-to-back, velocity-0 mapping.
    burst('{8'h32, 8'h00, 8'h34, 8'h40});
    settle();
    check("t2_count", 32'(q_a.size()), 32'd2);
    pop_a("t2a", C_NOFF, 4'd0, 7'd50, 7'd0);
    pop_a("t2b", C_NON,  4'd0, 7'd52, 7'd64);

    // Real-time byte in the middle of a message.
    q_b.delete();
    burst('{8'h91, 8'h40, 8'hF8, 8'h7F});
    settle();
    check("t3_count", 32'(q_a.size()), 32'd2);
    pop_a("t3a", C_SYS, 4'd8, 7'd0, 7'd0);
    pop_a("t3b", C_NON, 4'd1, 7'd64, 7'd127);
    check("t3_nrt_count", 32'(q_b.size()), 32'd1);
    if (q_b.size() != 0)
      check("t3_nrt_msg", 32'(q_b.pop_front()), 32'({C_NON, 4'd1, 7'd64, 7'd127}));

    // One-data-byte command with running status.
    burst('{8'hC5, 8'h0A, 8'h0B});
    settle();
    check("t4_count", 32'(q_a.size()), 32'd2);
    pop_a("t4a", C_PROG, 4'd5, 7'd10, 7'd0);
    pop_a("t4b", C_PROG, 4'd5, 7'd11, 7'd0);

    // SysEx discard, then an aborted note-on replaced by a CC.
    burst('{8'hF0, 8'h01, 8'h02, 8'hF7, 8'h40, 8'h41});
    settle();
    check("t5_sysex_count", 32'(q_a.size()), 32'd0);
    burst('{8'h90, 8'h32, 8'hB2, 8'h07, 8'h64});
    settle();
    check("t5_count", 32'(q_a.size()), 32'd1);
    pop_a("t5", C_CC, 4'd2, 7'd7, 7'd100);
    repeat (4) @(negedge clk);
    check("t5_hold_cmd", 32'(a_cmd), 32'(C_CC));
    check("t5_hold_d1",  32'(a_d1),  32'd100);
    check("t5_hold_rdy", 32'(a_rdy), 32'd0);

    // Pitch bend on another channel.
    burst('{8'hE3, 8'h00, 8'h40});
    settle();
    pop_a("t5pb", C_PB, 4'd3, 7'd0, 7'd64);

    // Reset mid-message loses the partial message.
    burst('{8'h90, 8'h32});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_in_reset");
    repeat (3) @(negedge clk);
    check_reset_outputs("t6_held");
    rst_n = 1'b1;
    send(8'h30);
    send(8'h40);
    settle();
    check("t6_count", 32'(q_a.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
